std_div_seq: RTL

STD_DIV_SEQ -- requirements
Module: std_div_seq

---
 rtl/std_div_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/std_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define STD_DIV_SEQ_SIGNED_EN to add the is_signed port for two's-complement division.
module std_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
`ifdef STD_DIV_SEQ_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmo_q, rmo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_raw, r_raw;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic             sgn;

`ifdef STD_DIV_SEQ_SIGNED_EN
    assign sgn = is_signed;
`else
    assign sgn = 1'b0;
`endif

    // Operands are divided as magnitudes; signs are reapplied on completion.
    assign a_mag = (sgn && left[WIDTH-1])  ? -left  : left;
    assign b_mag = (sgn && right[WIDTH-1]) ? -right : right;

    assign trial = {rem_q, dvd_q[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign take  = (trial >= {1'b0, dvs_q});
    assign q_raw = {dvd_q[WIDTH-2:0], take};
    assign r_raw = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

    // Divide by zero keeps the all-ones quotient regardless of sign.
    assign q_fin = (qneg_q && (dvs_q != '0)) ? -q_raw : q_raw;
    assign r_fin = rneg_q ? -r_raw : r_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    qneg_d  = sgn && (left[WIDTH-1] ^ right[WIDTH-1]);
                    rneg_d  = sgn && left[WIDTH-1];
                end
            end
            RUN: begin
                dvd_d = q_raw;
                rem_d = r_raw;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = q_fin;
                    rmo_d   = r_fin;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign out_quotient  = quo_q;
    assign out_remainder = rmo_q;
    assign done          = (state_q == DONE);
    assign busy          = (state_q != IDLE);

endmodule
